// File: rtl/rect_blitter.sv
// Rectangle rasteriser: one start pulse emits a clipped, row-major pixel stream
// for fill, erase or outline modes, and ends with a one-cycle done pulse.
module rect_blitter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int C_W      = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int BG_COLOR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [SIZE_W-1:0] width,
  input  logic [SIZE_W-1:0] height,
  input  logic [C_W-1:0]    c_in,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              plot,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [C_W-1:0]    c_out,
  output logic              done
);

  localparam int XS = X_W + 1;
  localparam int YS = Y_W + 1;
  localparam logic [XS-1:0]  X_LIM = XS'(X_MAX);
  localparam logic [YS-1:0]  Y_LIM = YS'(Y_MAX);
  localparam logic [C_W-1:0] BG    = C_W'(BG_COLOR);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [SIZE_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [SIZE_W-1:0]   w_q, w_d, h_q, h_d;
  logic [X_W-1:0]      x0_q, x0_d;
  logic [Y_W-1:0]      y0_q, y0_d;
  logic [C_W-1:0]      col_q, col_d;
  logic                outline_q, outline_d;

  logic                busy_q, busy_d, plot_q, plot_d, done_q, done_d;
  logic [X_W-1:0]      x_out_q, x_out_d;
  logic [Y_W-1:0]      y_out_q, y_out_d;
  logic [C_W-1:0]      c_out_q, c_out_d;

  logic [XS-1:0]       sum_x;
  logic [YS-1:0]       sum_y;
  logic                in_draw, border;

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    w_d       = w_q;
    h_d       = h_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    col_d     = col_q;
    outline_d = outline_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d      = x_in;
          y0_d      = y_in;
          w_d       = width;
          h_d       = height;
          col_d     = (mode == 2'b01) ? BG : c_in;
          outline_d = (mode == 2'b10);
          cx_d      = '0;
          cy_d      = '0;
          state_d   = (width == '0 || height == '0) ? S_DONE : S_DRAW;
        end
      end
      S_DRAW: begin
        if (cx_q == w_q - SIZE_W'(1)) begin
          cx_d = '0;
          if (cy_q == h_q - SIZE_W'(1)) state_d = S_DONE;
          else                          cy_d = cy_q + SIZE_W'(1);
        end else begin
          cx_d = cx_q + SIZE_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from next-state values so the registered pixel lines up with its state.
  always_comb begin
    in_draw = (state_d == S_DRAW);
    sum_x   = {1'b0, x0_d} + XS'(cx_d);
    sum_y   = {1'b0, y0_d} + YS'(cy_d);
    border  = (cx_d == '0) || (cx_d == w_d - SIZE_W'(1)) ||
              (cy_d == '0) || (cy_d == h_d - SIZE_W'(1));
    plot_d  = in_draw && (sum_x <= X_LIM) && (sum_y <= Y_LIM) && (!outline_d || border);
    x_out_d = in_draw ? sum_x[X_W-1:0] : '0;
    y_out_d = in_draw ? sum_y[Y_W-1:0] : '0;
    c_out_d = in_draw ? col_d : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      col_q     <= '0;
      outline_q <= 1'b0;
      busy_q    <= 1'b0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      c_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      col_q     <= col_d;
      outline_q <= outline_d;
      busy_q    <= busy_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      c_out_q   <= c_out_d;
    end
  end

  assign busy  = busy_q;
  assign plot  = plot_q;
  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_rect_blitter.sv
// Directed and randomized rectangles checked cycle by cycle against a
// nested-loop pixel model of the blitter's output stream.
module tb_rect_blitter;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] width, height;
  logic [2:0] c_in;
  logic [1:0] mode;
  logic       busy, plot, done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] c_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rect_blitter dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .width(width), .height(height),
    .c_in(c_in), .mode(mode),
    .busy(busy), .plot(plot), .x_out(x_out), .y_out(y_out),
    .c_out(c_out), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eb, input int ep, input int ed,
                         input int ex, input int ey, input int ec);
    chk({tag, ".busy"}, 32'(busy), eb);
    chk({tag, ".plot"}, 32'(plot), ep);
    chk({tag, ".done"}, 32'(done), ed);
    chk({tag, ".x"},    32'(x_out), ex);
    chk({tag, ".y"},    32'(y_out), ey);
    chk({tag, ".c"},    32'(c_out), ec);
  endtask

  // Junk on the inputs (including start) must not disturb a rectangle in flight.
  task automatic scramble();
    x_in   = 8'($urandom);
    y_in   = 7'($urandom);
    width  = 5'($urandom);
    height = 5'($urandom);
    c_in   = 3'($urandom);
    mode   = 2'($urandom);
    start  = 1'($urandom);
  endtask

  // Called in an idle cycle; returns in the idle cycle after the done pulse.
  task automatic run_rect(input string tag, input int x, input int y, input int w,
                          input int h, input int col, input int m);
    int ax, ay, ecol, ep;
    bit brd;
    x_in = 8'(x); y_in = 7'(y); width = 5'(w); height = 5'(h);
    c_in = 3'(col); mode = 2'(m); start = 1'b1;
    step();
    ecol = (m == 1) ? 0 : col;
    if (w != 0 && h != 0) begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          ax  = x + c;
          ay  = y + r;
          brd = (c == 0) || (c == w - 1) || (r == 0) || (r == h - 1);
          ep  = (ax <= 159 && ay <= 119 && (m != 2 || brd)) ? 1 : 0;
          chk_all($sformatf("%s.px(%0d,%0d)", tag, c, r), 1, ep, 0, ax % 256, ay % 128, ecol);
          scramble();
          step();
        end
      end
    end else begin
      scramble();
    end
    chk_all({tag, ".done"}, 1, 0, 1, 0, 0, 0);
    start = 1'($urandom);
    step();
    start = 1'b0;
    chk_all({tag, ".idle"}, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    x_in = '0; y_in = '0; width = '0; height = '0; c_in = '0; mode = '0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    run_rect("fill",    10, 20, 3, 2, 5, 0);
    run_rect("erase",   10, 20, 3, 2, 5, 1);
    run_rect("outline",  0,  0, 4, 4, 6, 2);
    run_rect("clip",   158, 118, 4, 3, 7, 0);
    run_rect("clipfar", 250, 126, 8, 4, 2, 2);
    run_rect("zero_w",  30, 30, 0, 3, 4, 0);
    run_rect("zero_h",  30, 30, 3, 0, 4, 0);
    run_rect("mode11",   5,  6, 2, 2, 3, 3);

    // Reset while the third pixel of a 5x5 fill is on the outputs.
    x_in = 8'd40; y_in = 7'd50; width = 5'd5; height = 5'd5; c_in = 3'd3; mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk_all("rst_mid.px3", 1, 1, 0, 42, 50, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("rst_mid.after", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_mid.idle", 0, 0, 0, 0, 0, 0);
    run_rect("after_rst", 40, 50, 2, 2, 1, 0);

    // Reset and start together: reset wins.
    x_in = 8'd1; y_in = 7'd1; width = 5'd2; height = 5'd2; start = 1'b1; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    chk_all("rst_start", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      run_rect($sformatf("rnd%0d", i),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
